// File: rtl/mealy_seq_decoder_pkg.sv
// Shared definitions for the two-state Mealy serial line code.
// The encoder (transmit side) and the decoder (receive side) both use this package.
package mealy_seq_decoder_pkg;

    // Line-code state. S0 passes bits through. S1 inverts the next bit.
    typedef enum logic {
        S0 = 1'b0,
        S1 = 1'b1
    } dec_state_e;

    // Default decoded word width.
    localparam int DEFAULT_WIDTH = 8;

    // Output map of the code. It is its own inverse: applied to an encoded
    // bit in the same state, it recovers the raw bit.
    function automatic logic mealy_out(input dec_state_e s, input logic b);
        return (s == S1) ? ~b : b;
    endfunction

    // State transition, driven by the raw (unencoded) bit.
    // A 1 in S0 moves to S1. S1 always returns to S0.
    function automatic dec_state_e mealy_next(input dec_state_e s, input logic raw_bit);
        return (s == S0 && raw_bit) ? S1 : S0;
    endfunction

endpackage

// File: rtl/mealy_bit_decoder.sv
// One-bit Mealy decoder: it tracks the remote encoder's state and recovers each raw bit.
// Built in three processes: state register, next-state logic and output logic.
module mealy_bit_decoder
    import mealy_seq_decoder_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic din_valid,
    input  logic frame_start,
    output logic dout,
    output logic dout_valid
);

    dec_state_e state_q;
    dec_state_e state_d;
    dec_state_e eff_state;

    // frame_start realigns the decode in the same cycle, so the incoming bit decodes in S0.
    assign eff_state = frame_start ? S0 : state_q;

    // State register. Reset takes effect immediately and decoding restarts in S0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S0;
        else       state_q <= state_d;
    end

    // Next state. The remote encoder advanced on the raw bit, which is the
    // recovered dout. Idle cycles hold the state, except that frame_start still realigns it.
    always_comb begin
        state_d = state_q;
        if (frame_start) state_d = S0;
        if (din_valid)   state_d = mealy_next(eff_state, dout);
    end

    // Output logic. dout is forced low whenever no bit is present.
    always_comb begin
        dout       = 1'b0;
        dout_valid = din_valid;
        if (din_valid) dout = mealy_out(eff_state, din);
    end

endmodule

// File: rtl/mealy_seq_decoder.sv
// Serial Mealy line decoder with word deserialiser and a valid/ready holding register.
// The first received bit of each word lands in word[0]. When a completed word
// finds the holding register full and not draining, the word is dropped and the
// sticky overrun flag is set.
module mealy_seq_decoder
    import mealy_seq_decoder_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_start,
    output logic             dout,
    output logic             dout_valid,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    logic             bit_dout;
    logic [CNT_W-1:0] cnt_q, cnt_d, eff_cnt;
    logic [WIDTH-1:0] shreg_q, shreg_d, done_val;
    logic             word_done;
    logic [WIDTH-1:0] word_q, word_d;
    logic             word_valid_q, word_valid_d;
    logic             overrun_q, overrun_d;
    logic             xfer, load, drop;

    mealy_bit_decoder u_bit_dec (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .dout        (bit_dout),
        .dout_valid  (dout_valid)
    );

    assign dout = bit_dout;

    // A realigned bit is bit 0 of a fresh word. Whatever partial word was in
    // the shift register is discarded rather than merged.
    assign eff_cnt = frame_start ? '0 : cnt_q;

    // Deserialiser. done_val is the shift register with the current bit
    // merged in, so a completed word is available in the cycle of its last bit.
    always_comb begin
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        done_val  = frame_start ? '0 : shreg_q;
        word_done = 1'b0;
        if (frame_start) begin
            cnt_d   = '0;
            shreg_d = '0;
        end
        if (din_valid) begin
            done_val[eff_cnt] = bit_dout;
            if (eff_cnt == LAST_IDX) begin
                word_done = 1'b1;
                cnt_d     = '0;
                shreg_d   = '0;
            end else begin
                cnt_d   = eff_cnt + CNT_W'(1);
                shreg_d = done_val;
            end
        end
    end

    // Holding register and overrun. A load in the same cycle as a transfer
    // gives back-to-back words. A new overrun wins over ovr_clr.
    always_comb begin
        xfer         = word_valid_q & word_ready;
        load         = word_done & (~word_valid_q | word_ready);
        drop         = word_done & ~load;
        word_d       = word_q;
        word_valid_d = word_valid_q;
        overrun_d    = overrun_q;
        if (load) begin
            word_d       = done_val;
            word_valid_d = 1'b1;
        end else if (xfer) begin
            word_valid_d = 1'b0;
        end
        if (drop)         overrun_d = 1'b1;
        else if (ovr_clr) overrun_d = 1'b0;
    end

    // Deserialiser state. Reset drops any partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // Output holding register and sticky overrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q       <= '0;
            word_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_mealy_seq_decoder.sv
// Bench for mealy_seq_decoder (WIDTH=8). Stimulus is raw bits passed through
// an encoder model. The expected decoded stream is the raw stream itself.
// Expected words are assembled from the raw bits collected since the last realignment.
module tb_mealy_seq_decoder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         din, din_valid, frame_start;
    logic         dout, dout_valid;
    logic [W-1:0] word;
    logic         word_valid, word_ready, overrun, ovr_clr;

    int nvec = 0;
    int nerr = 0;

    // Reference state: encoder model, collected raw bits, expected outputs.
    logic         enc_st;
    logic         bq[$];
    logic [W-1:0] exp_word;
    logic         exp_wv, exp_ovr;

    mealy_seq_decoder #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .word        (word),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .overrun     (overrun),
        .ovr_clr     (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        enc_st   = 1'b0;
        bq.delete();
        exp_word = '0;
        exp_wv   = 1'b0;
        exp_ovr  = 1'b0;
    endtask

    // One clock cycle. Entered and left 1 time unit after a rising edge.
    task automatic step(input logic dv, input logic raw, input logic fs,
                        input logic wr, input logic oc);
        logic         done, load, drop;
        logic [W-1:0] val;
        if (fs) begin
            enc_st = 1'b0;
            bq.delete();
        end
        din         = dv ? (enc_st ? ~raw : raw) : 1'($urandom_range(0, 1));
        din_valid   = dv;
        frame_start = fs;
        word_ready  = wr;
        ovr_clr     = oc;
        #1;
        chk("dout",       {31'd0, dout},       {31'd0, dv & raw});
        chk("dout_valid", {31'd0, dout_valid}, {31'd0, dv});
        chk("word",       {24'd0, word},       {24'd0, exp_word});
        chk("word_valid", {31'd0, word_valid}, {31'd0, exp_wv});
        chk("overrun",    {31'd0, overrun},    {31'd0, exp_ovr});
        done = 1'b0;
        val  = '0;
        if (dv) begin
            enc_st = enc_st ? 1'b0 : raw;
            bq.push_back(raw);
            if (bq.size() == W) begin
                done = 1'b1;
                for (int i = 0; i < W; i++) val[i] = bq[i];
                bq.delete();
            end
        end
        load = done && (!exp_wv || wr);
        drop = done && !load;
        if (load) begin
            exp_word = val;
            exp_wv   = 1'b1;
        end else if (exp_wv && wr) begin
            exp_wv = 1'b0;
        end
        if (drop)    exp_ovr = 1'b1;
        else if (oc) exp_ovr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] v, input logic fs, input logic wr, input logic oc);
        for (int i = 0; i < W; i++) step(1'b1, v[i], fs && (i == 0), wr, oc);
    endtask

    initial begin
        logic [W-1:0] a5;
        a5          = 8'hA5;
        reset       = 1'b1;
        din         = 1'b0;
        din_valid   = 1'b0;
        frame_start = 1'b0;
        word_ready  = 1'b0;
        ovr_clr     = 1'b0;
        model_reset();
        #1;
        chk("rst_word",  {24'd0, word},       32'd0);
        chk("rst_wv",    {31'd0, word_valid}, 32'd0);
        chk("rst_ovr",   {31'd0, overrun},    32'd0);
        chk("rst_dout",  {31'd0, dout},       32'd0);
        #20;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: raw 1,0,1,1 -> encoded 1,1,1,0; decode recovers the raw bits.
        step(1, 1, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);

        // 2: 0xA5 realigned, ready high; word_valid high for exactly one cycle.
        send_word(8'hA5, 1, 1, 0);
        chk("t2_word", {24'd0, word}, 32'h0000_00A5);
        chk("t2_wv1",  {31'd0, word_valid}, 32'd1);
        step(0, 0, 0, 1, 0);
        chk("t2_wv0",  {31'd0, word_valid}, 32'd0);

        // 3: same stream with 3 idle cycles after bit 0 (decoder sitting in S1).
        step(1, a5[0], 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        for (int i = 1; i < W; i++) step(1, a5[i], 0, 1, 0);
        chk("t3_word", {24'd0, word}, 32'h0000_00A5);
        step(0, 0, 0, 1, 0);

        // 4: not ready; 0x3C is held, 0xFF is dropped -> overrun. The set wins over ovr_clr.
        send_word(8'h3C, 1, 0, 0);
        send_word(8'hFF, 0, 0, 1);
        chk("t4_word", {24'd0, word},    32'h0000_003C);
        chk("t4_ovr",  {31'd0, overrun}, 32'd1);
        step(0, 0, 0, 0, 1);
        chk("t4_clr",  {31'd0, overrun}, 32'd0);
        step(0, 0, 0, 1, 0);

        // 5: garbage bits, then realign on the first bit of 0x5A.
        for (int i = 0; i < 3; i++) step(1, 1'($urandom_range(0, 1)), 0, 1, 0);
        send_word(8'h5A, 1, 1, 0);
        chk("t5_word", {24'd0, word}, 32'h0000_005A);
        step(0, 0, 0, 1, 0);

        // 6: asynchronous reset mid-word in S1, with a word held and overrun set.
        send_word(8'h3C, 1, 0, 0);
        send_word(8'hFF, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        din_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_wv",   {31'd0, word_valid}, 32'd0);
        chk("t6_word", {24'd0, word},       32'd0);
        chk("t6_ovr",  {31'd0, overrun},    32'd0);
        model_reset();
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_word(8'hA5, 0, 1, 0);
        chk("t6_a5", {24'd0, word}, 32'h0000_00A5);

        // Random traffic: gaps, realignments, back-pressure, clears.
        for (int n = 0; n < 600; n++)
            step(($urandom % 4) != 0, 1'($urandom_range(0, 1)), ($urandom % 23) == 0,
                 ($urandom % 3) != 0, ($urandom % 11) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
